// File: rtl/fwrisc_uart_tx.sv
// fwrisc_uart_tx: byte FIFO feeding an 8N1 UART serialiser on the 'tx' pin.
module fwrisc_uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 16,
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  output logic          tx,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);

  localparam int unsigned DIV = CLK_FREQ_HZ / BAUD;
  localparam int unsigned BCW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  // Reject parameter sets the counters and pointer wrap cannot support.
  if (DIV < 2) begin : g_div_check
    $error("fwrisc_uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("fwrisc_uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [BCW-1:0]  baud, baud_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [7:0]      shift, shift_d;
  logic            tx_d;
  logic            pop;
  logic            push;
  logic            fifo_empty;
  logic            fifo_full;
  logic            baud_end;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      head;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign wr_ready   = reset && !fifo_full;
  assign push       = wr_valid && wr_ready;
  assign busy       = (state != IDLE) || !fifo_empty;
  assign head       = mem[rd_ptr];
  assign baud_end   = (baud == BCW'(DIV - 1));

  // Byte storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Serialiser state register; tx idles high and returns high on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      tx      <= tx_d;
    end
  end

  // Next state: each bit lasts DIV clocks; the stop bit chains straight into the next start.
  always_comb begin
    state_d   = state;
    baud_d    = baud + BCW'(1);
    bit_idx_d = bit_idx;
    shift_d   = shift;
    tx_d      = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d    = '0;
          tx_d      = shift[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d   = {1'b0, shift[7:1]};
            tx_d      = shift[1];
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fwrisc_uart_tx.sv
// Directed self-checking bench for fwrisc_uart_tx (DIV=10, FIFO_DEPTH=4).
module tb_fwrisc_uart_tx;

  logic       clock;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q [$];

  fwrisc_uart_tx #(
    .CLK_FREQ_HZ(1000),
    .BAUD       (100),
    .FIFO_DEPTH (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Line receiver: decodes frames off tx by cycle counting; frames cut by reset are dropped.
  initial begin : line_monitor
    logic       prev;
    logic       ok;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (reset && prev && !tx) begin
        ok = 1'b1;
        b  = '0;
        repeat (5) begin @(posedge clock); #1; if (!reset) ok = 1'b0; end
        if (tx !== 1'b0) ok = 1'b0;
        for (int j = 0; j < 8; j++) begin
          repeat (10) begin @(posedge clock); #1; if (!reset) ok = 1'b0; end
          b[j] = tx;
        end
        repeat (10) begin @(posedge clock); #1; if (!reset) ok = 1'b0; end
        if (tx !== 1'b1) ok = 1'b0;
        if (ok) rx_q.push_back(b);
      end
      prev = tx;
    end
  end

  task automatic push_at_edge(input logic [7:0] d);
    @(negedge clock);
    wr_valid = 1'b1;
    wr_data  = d;
    @(posedge clock); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle wait: busy=%b after %0d cycles, expected 0", name, busy, n);
    end
  endtask

  // Compares tx cycle by cycle against the expected frame(s), starting after edge k+c0.
  task automatic check_stream(input logic [7:0] b0, input logic [7:0] b1,
                              input int n, input int c0, input string name);
    logic [7:0] bb;
    int         f;
    int         bi;
    logic       exp_bit;
    for (int c = c0; c <= 100 * n; c++) begin
      @(posedge clock); #1;
      f  = (c - 1) / 100;
      bi = ((c - 1) % 100) / 10;
      bb = (f == 0) ? b0 : b1;
      if (bi == 0)      exp_bit = 1'b0;
      else if (bi == 9) exp_bit = 1'b1;
      else              exp_bit = bb[bi-1];
      checks++;
      if (tx !== exp_bit) begin
        errors++;
        $display("FAIL %s tx at cycle %0d: got %b expected %b", name, c, tx, exp_bit);
      end
      if (n == 2 && (c == 100 || c == 101)) begin
        checks++;
        if (fifo_count !== ((c == 100) ? 3'd1 : 3'd0)) begin
          errors++;
          $display("FAIL %s count at cycle %0d: got %0d expected %0d",
                   name, c, fifo_count, (c == 100) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'hC3;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({tx, wr_ready, busy, fifo_count} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: tx=%b ready=%b busy=%b count=%0d expected 1 0 0 0",
               tx, wr_ready, busy, fifo_count);
    end
    @(negedge clock);
    wr_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({tx, wr_ready, busy} !== 3'b110) begin
      errors++;
      $display("FAIL reset_release: tx=%b ready=%b busy=%b expected 1 1 0", tx, wr_ready, busy);
    end
  endtask

  task automatic test_single_a5();
    rx_q.delete();
    push_at_edge(8'hA5);
    check_stream(8'hA5, 8'h00, 1, 1, "single_a5");
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_a5 busy at k+100: got %b expected 1", busy);
    end
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_a5 end at k+101: busy=%b tx=%b expected 0 1", busy, tx);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_a5 received: size=%0d first=%h expected 1 a5",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    rx_q.delete();
    @(negedge clock);
    wr_valid = 1'b1;
    wr_data  = 8'h00;
    @(posedge clock); #1;
    checks++;
    if (fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL b2b count at k: got %0d expected 1", fifo_count);
    end
    wr_data = 8'hFF;
    @(posedge clock); #1;
    wr_valid = 1'b0;
    checks++;
    if (tx !== 1'b0 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL b2b at k+1: tx=%b count=%0d expected 0 1", tx, fifo_count);
    end
    check_stream(8'h00, 8'hFF, 2, 2, "b2b");
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b busy at k+201: got %b expected 0", busy);
    end
  endtask

  task automatic test_burst();
    logic [7:0] d [6];
    int         i;
    int         cyc;
    logic       acc;
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rx_q.delete();
    i   = 0;
    cyc = 0;
    while (i < 6 && cyc < 3000) begin
      @(negedge clock);
      wr_valid = 1'b1;
      wr_data  = d[i];
      acc      = wr_ready;
      if (!acc) begin
        checks++;
        if (fifo_count !== 3'd4) begin
          errors++;
          $display("FAIL burst stall with count=%0d expected 4", fifo_count);
        end
      end
      @(posedge clock);
      if (acc) i++;
      cyc++;
    end
    @(negedge clock);
    wr_valid = 1'b0;
    checks++;
    if (i != 6) begin
      errors++;
      $display("FAIL burst accepted %0d bytes expected 6", i);
    end
    wait_idle("burst");
    repeat (2) @(posedge clock);
    checks++;
    if (rx_q.size() != 6) begin
      errors++;
      $display("FAIL burst frame count: got %0d expected 6", rx_q.size());
    end
    for (int j = 0; j < 6; j++) begin
      if (j < rx_q.size()) begin
        checks++;
        if (rx_q[j] !== d[j]) begin
          errors++;
          $display("FAIL burst byte %0d: got %h expected %h", j, rx_q[j], d[j]);
        end
      end
    end
  endtask

  task automatic test_push_pop_same_edge();
    logic [7:0] d [4];
    d = '{8'h5A, 8'hC3, 8'h0F, 8'h96};
    rx_q.delete();
    push_at_edge(d[0]);
    push_at_edge(d[1]);
    push_at_edge(d[2]);
    repeat (98) @(posedge clock);
    @(negedge clock);
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL pushpop count before edge: got %0d expected 2", fifo_count);
    end
    wr_valid = 1'b1;
    wr_data  = d[3];
    @(posedge clock); #1;
    wr_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd2 || tx !== 1'b0) begin
      errors++;
      $display("FAIL pushpop after edge: count=%0d tx=%b expected 2 0", fifo_count, tx);
    end
    wait_idle("pushpop");
    repeat (2) @(posedge clock);
    checks++;
    if (rx_q.size() != 4) begin
      errors++;
      $display("FAIL pushpop frame count: got %0d expected 4", rx_q.size());
    end
    for (int j = 0; j < 4; j++) begin
      if (j < rx_q.size()) begin
        checks++;
        if (rx_q[j] !== d[j]) begin
          errors++;
          $display("FAIL pushpop byte %0d: got %h expected %h", j, rx_q[j], d[j]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int lows;
    rx_q.delete();
    push_at_edge(8'h3C);
    push_at_edge(8'h81);
    push_at_edge(8'h7E);
    repeat (43) @(posedge clock);
    #1;
    checks++;
    if (tx !== 1'b1 || fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL midreset pre: tx=%b count=%0d expected 1 2", tx, fifo_count);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({tx, wr_ready, busy, fifo_count} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL midreset async: tx=%b ready=%b busy=%b count=%0d expected 1 0 0 0",
               tx, wr_ready, busy, fifo_count);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    lows = 0;
    repeat (150) begin
      @(posedge clock); #1;
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0 || busy !== 1'b0 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL midreset quiet: low_cycles=%0d busy=%b frames=%0d expected 0 0 0",
               lows, busy, rx_q.size());
    end
    push_at_edge(8'hE7);
    @(posedge clock); #1;
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL midreset restart tx: got %b expected 0", tx);
    end
    wait_idle("midreset");
    repeat (2) @(posedge clock);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hE7) begin
      errors++;
      $display("FAIL midreset restart frame: size=%0d first=%h expected 1 e7",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  initial begin
    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    test_reset();
    repeat (3) @(posedge clock);
    test_single_a5();
    repeat (5) @(posedge clock);
    test_back_to_back();
    repeat (5) @(posedge clock);
    test_burst();
    repeat (5) @(posedge clock);
    test_push_pop_same_edge();
    repeat (5) @(posedge clock);
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
